// File: rtl/spmc_spi_slave.sv
// rtl/spmc_spi_slave.sv - SPI mode-0 slave with an MC peripheral register port
//
// Purpose: receives and transmits bytes as an SPI mode-0 (MSB first) slave and
// exposes them to the microcontroller through four peripheral registers.
//
// Ports:
//   clk_peri     in   1  system clock, the only clock in the block
//   reset        in   1  asynchronous, active-low reset
//   do_peri      in  18  write data from the MC
//   di_peri      out 18  read data to the MC, valid one cycle after the read
//   addr_peri    in  10  peripheral address ([9:6] block select, [1:0] register)
//   access_peri  in   1  peripheral access strobe
//   wr_peri      in   1  write enable (1 = write, 0 = read)
//   spi_sclk     in   1  SPI clock from the master
//   spi_mosi     in   1  master-out data
//   spi_cs_n     in   1  chip select, active-low
//   spi_miso     out  1  slave-out data
//   spi_miso_oe  out  1  MISO pad output enable
//   irq          out  1  interrupt request
//
// Registers (offset): 0 DATA, 1 STATUS, 2 CTRL, 3 reserved (reads 0).

module spmc_spi_slave #(
  parameter logic [9:0] BASE_ADR   = 10'h0,
  parameter logic [7:0] DUMMY_BYTE = 8'hFF
) (
  input  logic        clk_peri,
  input  logic        reset,
  input  logic [17:0] do_peri,
  output logic [17:0] di_peri,
  input  logic [9:0]  addr_peri,
  input  logic        access_peri,
  input  logic        wr_peri,
  input  logic        spi_sclk,
  input  logic        spi_mosi,
  input  logic        spi_cs_n,
  output logic        spi_miso,
  output logic        spi_miso_oe,
  output logic        irq
);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  localparam logic [1:0] OFS_DATA   = 2'd0;
  localparam logic [1:0] OFS_STATUS = 2'd1;
  localparam logic [1:0] OFS_CTRL   = 2'd2;

  // Synchronizers and edge-detect history
  logic       sclk_meta, sclk_sync, sclk_prev;
  logic       mosi_meta, mosi_sync;
  logic       cs_meta, cs_sync, cs_prev;
  logic [1:0] sync_ok;
  logic       cs_armed;

  // Core state
  state_t     state;
  logic [7:0] rx_shift;
  logic [7:0] tx_shift;
  logic [2:0] bit_cnt;
  logic [7:0] rx_data;
  logic [7:0] tx_hold;
  logic       rx_valid;
  logic       tx_full;
  logic       overrun;
  logic       underrun;
  logic       rx_ie;
  logic       tx_ie;

  // Decode / datapath helpers
  logic        sel, rd_en, wr_en;
  logic        data_rd, data_wr, status_wr, ctrl_wr;
  logic        sclk_rise, sclk_fall, cs_fall, cs_rise;
  logic        cs_active;
  logic        byte_done, capture, tx_load;
  logic [7:0]  rx_next;
  logic [7:0]  load_byte;
  logic [17:0] rd_mux;
  logic        unused_bits;

  // Input synchronizers. The reset values model an idle bus (cs high, sclk low).
  // sync_ok marks when cs_sync reflects the real pin after reset; cs_armed is
  // then set only once cs has been seen high, so a cs_n held low across reset
  // release never looks like a fresh falling edge.
  always_ff @(posedge clk_peri or negedge reset) begin
    if (!reset) begin
      sclk_meta <= 1'b0;
      sclk_sync <= 1'b0;
      sclk_prev <= 1'b0;
      mosi_meta <= 1'b0;
      mosi_sync <= 1'b0;
      cs_meta   <= 1'b1;
      cs_sync   <= 1'b1;
      cs_prev   <= 1'b1;
      sync_ok   <= 2'b00;
      cs_armed  <= 1'b0;
    end else begin
      sclk_meta <= spi_sclk;
      sclk_sync <= sclk_meta;
      sclk_prev <= sclk_sync;
      mosi_meta <= spi_mosi;
      mosi_sync <= mosi_meta;
      cs_meta   <= spi_cs_n;
      cs_sync   <= cs_meta;
      cs_prev   <= cs_sync;
      sync_ok   <= {sync_ok[0], 1'b1};
      if (sync_ok[1] && cs_sync) begin
        cs_armed <= 1'b1;
      end
    end
  end

  assign sclk_rise = sclk_sync & ~sclk_prev;
  assign sclk_fall = ~sclk_sync & sclk_prev;
  assign cs_fall   = cs_prev & ~cs_sync & cs_armed;
  assign cs_rise   = cs_sync & ~cs_prev;
  assign cs_active = (state == ST_ACTIVE);

  // Register decode
  assign sel       = access_peri && (addr_peri[9:6] == BASE_ADR[9:6]);
  assign rd_en     = sel & ~wr_peri;
  assign wr_en     = sel & wr_peri;
  assign data_rd   = rd_en && (addr_peri[1:0] == OFS_DATA);
  assign data_wr   = wr_en && (addr_peri[1:0] == OFS_DATA);
  assign status_wr = wr_en && (addr_peri[1:0] == OFS_STATUS);
  assign ctrl_wr   = wr_en && (addr_peri[1:0] == OFS_CTRL);

  // SPI datapath events. A cs rise takes priority over any same-cycle edge.
  assign rx_next   = {rx_shift[6:0], mosi_sync};
  assign byte_done = cs_active && !cs_rise && sclk_rise && (bit_cnt == 3'd7);
  // A same-cycle DATA read frees the buffer, so the new byte is still captured.
  assign capture   = byte_done && (!rx_valid || data_rd);
  assign tx_load   = (!cs_active && cs_fall) ||
                     (cs_active && !cs_rise && sclk_fall && (bit_cnt == 3'd0));
  assign load_byte = tx_full ? tx_hold : DUMMY_BYTE;

  always_comb begin
    rd_mux = 18'd0;
    case (addr_peri[1:0])
      OFS_DATA:   rd_mux = {10'd0, rx_data};
      OFS_STATUS: rd_mux = {13'd0, underrun, cs_active, overrun, tx_full, rx_valid};
      OFS_CTRL:   rd_mux = {16'd0, tx_ie, rx_ie};
      default:    rd_mux = 18'd0;
    endcase
  end

  // Main state machine, shifters, flags and registered outputs.
  // Statement order matters where several events touch one flag in the
  // same cycle: later assignments win.
  always_ff @(posedge clk_peri or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      rx_shift <= 8'd0;
      tx_shift <= 8'd0;
      bit_cnt  <= 3'd0;
      rx_data  <= 8'd0;
      tx_hold  <= 8'd0;
      rx_valid <= 1'b0;
      tx_full  <= 1'b0;
      overrun  <= 1'b0;
      underrun <= 1'b0;
      rx_ie    <= 1'b0;
      tx_ie    <= 1'b0;
      irq      <= 1'b0;
      di_peri  <= 18'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cs_fall) begin
            state   <= ST_ACTIVE;
            bit_cnt <= 3'd0;
          end
        end
        ST_ACTIVE: begin
          if (cs_rise) begin
            // Partial byte is dropped: no rx_valid / overrun update.
            state   <= ST_IDLE;
            bit_cnt <= 3'd0;
          end else if (sclk_rise) begin
            rx_shift <= rx_next;
            bit_cnt  <= bit_cnt + 3'd1;
          end else if (sclk_fall && (bit_cnt != 3'd0)) begin
            tx_shift <= {tx_shift[6:0], 1'b0};
          end
        end
        default: state <= ST_IDLE;
      endcase

      // Status clears go first so a same-cycle set event is not lost.
      if (status_wr) begin
        if (do_peri[2]) overrun  <= 1'b0;
        if (do_peri[4]) underrun <= 1'b0;
      end

      // TX load uses the pre-write tx_hold/tx_full; a same-cycle DATA write
      // below then leaves tx_full set with the new byte.
      if (tx_load) begin
        tx_shift <= load_byte;
        if (tx_full) begin
          tx_full <= 1'b0;
        end else begin
          underrun <= 1'b1;
        end
      end

      if (data_wr) begin
        tx_hold <= do_peri[7:0];
        tx_full <= 1'b1;
      end

      if (data_rd) begin
        rx_valid <= 1'b0;
      end
      if (capture) begin
        rx_data  <= rx_next;
        rx_valid <= 1'b1;
      end else if (byte_done) begin
        overrun <= 1'b1;
      end

      if (ctrl_wr) begin
        rx_ie <= do_peri[0];
        tx_ie <= do_peri[1];
      end

      di_peri <= rd_en ? rd_mux : 18'd0;
      irq     <= (rx_ie & rx_valid) | (tx_ie & ~tx_full);
    end
  end

  assign spi_miso    = cs_active ? tx_shift[7] : 1'b1;
  assign spi_miso_oe = cs_active;

  assign unused_bits = ^{do_peri[17:8], do_peri[3], do_peri[1:0], addr_peri[5:2]};

endmodule

// File: tb/tb_spmc_spi_slave.sv
// tb/tb_spmc_spi_slave.sv - self-checking bench for spmc_spi_slave
module tb_spmc_spi_slave;

  localparam logic [9:0] BASE     = 10'h0C0;
  localparam logic [9:0] A_DATA   = BASE + 10'd0;
  localparam logic [9:0] A_STATUS = BASE + 10'd1;
  localparam logic [9:0] A_CTRL   = BASE + 10'd2;
  localparam logic [9:0] A_RSVD   = BASE + 10'd3;
  localparam logic [7:0] DUMMY    = 8'hFF;
  localparam int         HALF     = 8;

  logic        clk_peri = 1'b0;
  logic        reset = 1'b0;
  logic [17:0] do_peri = '0;
  logic [17:0] di_peri;
  logic [9:0]  addr_peri = '0;
  logic        access_peri = 1'b0;
  logic        wr_peri = 1'b0;
  logic        spi_sclk = 1'b0;
  logic        spi_mosi = 1'b0;
  logic        spi_cs_n = 1'b1;
  logic        spi_miso;
  logic        spi_miso_oe;
  logic        irq;

  spmc_spi_slave #(.BASE_ADR(BASE), .DUMMY_BYTE(DUMMY)) dut (
    .clk_peri(clk_peri), .reset(reset), .do_peri(do_peri), .di_peri(di_peri),
    .addr_peri(addr_peri), .access_peri(access_peri), .wr_peri(wr_peri),
    .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_cs_n(spi_cs_n),
    .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe), .irq(irq)
  );

  always #5 clk_peri = ~clk_peri;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [17:0] act, input logic [17:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk_peri);
  endtask

  task automatic reg_write(input logic [9:0] a, input logic [17:0] d);
    addr_peri = a; do_peri = d; wr_peri = 1'b1; access_peri = 1'b1;
    wait_clks(1);
    access_peri = 1'b0; wr_peri = 1'b0;
  endtask

  task automatic reg_read(input logic [9:0] a, output logic [17:0] d, output logic [17:0] idle);
    addr_peri = a; wr_peri = 1'b0; access_peri = 1'b1;
    wait_clks(1);
    access_peri = 1'b0;
    d = di_peri;
    wait_clks(1);
    idle = di_peri;
  endtask

  task automatic spi_bits(input logic [7:0] mo, input int n, output logic [7:0] mi);
    mi = 8'd0;
    for (int i = 0; i < n; i++) begin
      spi_mosi = mo[7-i];
      wait_clks(HALF);
      mi = {mi[6:0], spi_miso};
      spi_sclk = 1'b1;
      wait_clks(HALF);
      spi_sclk = 1'b0;
    end
  endtask

  task automatic cs_low();
    spi_cs_n = 1'b0;
    wait_clks(HALF);
  endtask

  task automatic cs_high();
    wait_clks(HALF);
    spi_cs_n = 1'b1;
    wait_clks(HALF);
  endtask

  // Transaction-level reference model
  logic [7:0] m_tx_hold, m_rx_data;
  logic       m_tx_full, m_rx_valid, m_overrun, m_underrun, m_rx_ie, m_tx_ie;

  task automatic m_reset();
    m_tx_hold = 8'd0; m_rx_data = 8'd0; m_tx_full = 1'b0; m_rx_valid = 1'b0;
    m_overrun = 1'b0; m_underrun = 1'b0; m_rx_ie = 1'b0; m_tx_ie = 1'b0;
  endtask

  task automatic m_load(output logic [7:0] b);
    if (m_tx_full) begin
      b = m_tx_hold; m_tx_full = 1'b0;
    end else begin
      b = DUMMY; m_underrun = 1'b1;
    end
  endtask

  task automatic m_byte(input logic [7:0] b);
    if (!m_rx_valid) begin
      m_rx_data = b; m_rx_valid = 1'b1;
    end else begin
      m_overrun = 1'b1;
    end
  endtask

  // Directed vector table
  typedef enum int {V_WR, V_RD, V_CSL, V_CSH, V_BYTE, V_IRQ} vop_t;
  typedef struct {
    vop_t        op;
    logic [9:0]  addr;
    logic [17:0] data;
    logic [17:0] exp;
    int          nbits;
  } vec_t;
  vec_t vecs[$];

  task automatic add(input vop_t op, input logic [9:0] a, input logic [17:0] d,
                     input logic [17:0] e, input int n);
    vec_t v;
    v.op = op; v.addr = a; v.data = d; v.exp = e; v.nbits = n;
    vecs.push_back(v);
  endtask

  logic [17:0] rd, idle, rw;
  logic [7:0]  mi, rb, cur;
  int          op, nb, nbits;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Scenario: write A5, master sends 3C
    add(V_WR,   A_DATA,   18'h0A5, 18'h0,   0);
    add(V_RD,   A_STATUS, 18'h0,   18'h002, 0);
    add(V_CSL,  '0,       18'h0,   18'h0,   0);
    add(V_RD,   A_STATUS, 18'h0,   18'h008, 0);
    add(V_BYTE, '0,       18'h03C, 18'h0A5, 8);
    add(V_CSH,  '0,       18'h0,   18'h0,   0);
    add(V_RD,   A_STATUS, 18'h0,   18'h011, 0);
    add(V_RD,   A_DATA,   18'h0,   18'h03C, 0);
    // TX empty -> dummy byte, underrun and its clear
    add(V_CSL,  '0,       18'h0,   18'h0,   0);
    add(V_BYTE, '0,       18'h05A, 18'h0FF, 8);
    add(V_CSH,  '0,       18'h0,   18'h0,   0);
    add(V_RD,   A_STATUS, 18'h0,   18'h011, 0);
    add(V_WR,   A_STATUS, 18'h010, 18'h0,   0);
    add(V_RD,   A_STATUS, 18'h0,   18'h001, 0);
    add(V_RD,   A_DATA,   18'h0,   18'h05A, 0);
    // Two bytes without a read -> overrun, first byte kept
    add(V_CSL,  '0,       18'h0,   18'h0,   0);
    add(V_BYTE, '0,       18'h081, 18'h0FF, 8);
    add(V_BYTE, '0,       18'h07E, 18'h0FF, 8);
    add(V_CSH,  '0,       18'h0,   18'h0,   0);
    add(V_RD,   A_STATUS, 18'h0,   18'h015, 0);
    add(V_RD,   A_DATA,   18'h0,   18'h081, 0);
    add(V_WR,   A_STATUS, 18'h014, 18'h0,   0);
    add(V_RD,   A_STATUS, 18'h0,   18'h000, 0);
    // CS raised after 5 bits, then a full byte
    add(V_CSL,  '0,       18'h0,   18'h0,   0);
    add(V_BYTE, '0,       18'h0C0, 18'h0FF, 5);
    add(V_CSH,  '0,       18'h0,   18'h0,   0);
    add(V_RD,   A_STATUS, 18'h0,   18'h010, 0);
    add(V_CSL,  '0,       18'h0,   18'h0,   0);
    add(V_BYTE, '0,       18'h096, 18'h0FF, 8);
    add(V_CSH,  '0,       18'h0,   18'h0,   0);
    add(V_RD,   A_DATA,   18'h0,   18'h096, 0);
    add(V_WR,   A_STATUS, 18'h010, 18'h0,   0);
    // Interrupts
    add(V_WR,   A_CTRL,   18'h001, 18'h0,   0);
    add(V_RD,   A_CTRL,   18'h0,   18'h001, 0);
    add(V_IRQ,  '0,       18'h0,   18'h0,   0);
    add(V_CSL,  '0,       18'h0,   18'h0,   0);
    add(V_BYTE, '0,       18'h042, 18'h0FF, 8);
    add(V_CSH,  '0,       18'h0,   18'h0,   0);
    add(V_IRQ,  '0,       18'h0,   18'h1,   0);
    add(V_RD,   A_DATA,   18'h0,   18'h042, 0);
    add(V_IRQ,  '0,       18'h0,   18'h0,   0);
    // Reserved offset, decode boundaries, tx interrupt
    add(V_WR,   A_RSVD,   18'h3FFFF, 18'h0, 0);
    add(V_RD,   A_RSVD,   18'h0,   18'h000, 0);
    add(V_RD,   A_CTRL,   18'h0,   18'h001, 0);
    add(V_WR,   A_CTRL,   18'h002, 18'h0,   0);
    add(V_IRQ,  '0,       18'h0,   18'h1,   0);
    add(V_WR,   A_DATA,   18'h011, 18'h0,   0);
    add(V_IRQ,  '0,       18'h0,   18'h0,   0);
    add(V_WR,   A_CTRL,   18'h000, 18'h0,   0);
    add(V_RD,   BASE ^ 10'h041, 18'h0, 18'h000, 0);
    add(V_RD,   BASE | 10'h03D, 18'h0, 18'h012, 0);

    // Reset values
    wait_clks(3);
    chk("rst_di", di_peri, 18'h0);
    chk("rst_miso", {17'h0, spi_miso}, 18'h1);
    chk("rst_oe", {17'h0, spi_miso_oe}, 18'h0);
    chk("rst_irq", {17'h0, irq}, 18'h0);
    reset = 1'b1;
    wait_clks(5);

    for (int i = 0; i < vecs.size(); i++) begin
      case (vecs[i].op)
        V_WR:  reg_write(vecs[i].addr, vecs[i].data);
        V_RD: begin
          reg_read(vecs[i].addr, rd, idle);
          chk($sformatf("vec%0d_rd", i), rd, vecs[i].exp);
          chk($sformatf("vec%0d_idle", i), idle, 18'h0);
        end
        V_CSL: cs_low();
        V_CSH: cs_high();
        V_BYTE: begin
          spi_bits(vecs[i].data[7:0], vecs[i].nbits, mi);
          chk($sformatf("vec%0d_miso", i), {10'h0, mi}, vecs[i].exp >> (8 - vecs[i].nbits));
        end
        V_IRQ: begin
          wait_clks(2);
          chk($sformatf("vec%0d_irq", i), {17'h0, irq}, vecs[i].exp);
        end
        default: ;
      endcase
    end

    // Reset in mid-byte, cs_n held low across release
    cs_low();
    spi_bits(8'hF0, 4, mi);
    chk("pre_rst_oe", {17'h0, spi_miso_oe}, 18'h1);
    reset = 1'b0;
    #1;
    chk("mid_rst_miso", {17'h0, spi_miso}, 18'h1);
    chk("mid_rst_oe", {17'h0, spi_miso_oe}, 18'h0);
    chk("mid_rst_irq", {17'h0, irq}, 18'h0);
    chk("mid_rst_di", di_peri, 18'h0);
    wait_clks(3);
    reset = 1'b1;
    wait_clks(10);
    chk("no_fresh_edge_oe", {17'h0, spi_miso_oe}, 18'h0);
    reg_read(A_STATUS, rd, idle); chk("post_rst_status", rd, 18'h0);
    reg_read(A_CTRL, rd, idle);   chk("post_rst_ctrl", rd, 18'h0);
    reg_read(A_DATA, rd, idle);   chk("post_rst_data", rd, 18'h0);
    spi_cs_n = 1'b1;
    wait_clks(HALF);
    cs_low();
    spi_bits(8'h3C, 8, mi);
    chk("post_rst_miso", {10'h0, mi}, 18'h0FF);
    cs_high();
    reg_read(A_DATA, rd, idle); chk("post_rst_rx", rd, 18'h03C);

    // DATA write in the same cycle as the entry tx load
    spi_cs_n = 1'b0;
    wait_clks(2);
    reg_write(A_DATA, 18'h06B);
    wait_clks(HALF - 3);
    reg_read(A_STATUS, rd, idle); chk("wr_load_status", rd, 18'h01A);
    spi_bits(8'h12, 8, mi); chk("wr_load_miso0", {10'h0, mi}, 18'h0FF);
    spi_bits(8'h34, 8, mi); chk("wr_load_miso1", {10'h0, mi}, 18'h06B);
    cs_high();
    reg_read(A_DATA, rd, idle);   chk("wr_load_rx", rd, 18'h012);
    reg_read(A_STATUS, rd, idle); chk("wr_load_status2", rd, 18'h014);
    reg_write(A_STATUS, 18'h014);

    // DATA read in the same cycle as byte completion
    cs_low();
    spi_bits(8'h5E, 8, mi); chk("rd_done_miso0", {10'h0, mi}, 18'h0FF);
    spi_bits(8'hC3, 7, mi); chk("rd_done_miso1", {10'h0, mi}, 18'h07F);
    spi_mosi = 1'b1;
    wait_clks(HALF);
    spi_sclk = 1'b1;
    wait_clks(2);
    addr_peri = A_DATA; wr_peri = 1'b0; access_peri = 1'b1;
    wait_clks(1);
    access_peri = 1'b0;
    chk("rd_done_old", di_peri, 18'h05E);
    wait_clks(HALF - 3);
    spi_sclk = 1'b0;
    cs_high();
    reg_read(A_STATUS, rd, idle); chk("rd_done_status", rd, 18'h011);
    reg_read(A_DATA, rd, idle);   chk("rd_done_new", rd, 18'h0C3);

    // Randomized phase against the reference model
    reset = 1'b0;
    wait_clks(2);
    reset = 1'b1;
    m_reset();
    wait_clks(5);
    for (int it = 0; it < 80; it++) begin
      op = int'($urandom_range(0, 6));
      case (op)
        0: begin
          rb = 8'($urandom);
          reg_write(A_DATA, {10'($urandom), rb});
          m_tx_hold = rb; m_tx_full = 1'b1;
        end
        1: begin
          reg_read(A_DATA, rd, idle);
          chk("rnd_data", rd, {10'h0, m_rx_data});
          m_rx_valid = 1'b0;
        end
        2: begin
          reg_read(A_STATUS, rd, idle);
          chk("rnd_status", rd, {13'h0, m_underrun, 1'b0, m_overrun, m_tx_full, m_rx_valid});
        end
        3: begin
          rw = 18'($urandom);
          reg_write(A_CTRL, rw);
          m_rx_ie = rw[0]; m_tx_ie = rw[1];
        end
        4: begin
          rw = 18'($urandom);
          reg_write(A_STATUS, rw);
          if (rw[2]) m_overrun = 1'b0;
          if (rw[4]) m_underrun = 1'b0;
        end
        5: begin
          nb = int'($urandom_range(1, 2));
          cs_low();
          m_load(cur);
          for (int k = 0; k < nb; k++) begin
            rb = 8'($urandom);
            nbits = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7)) : 8;
            spi_bits(rb, nbits, mi);
            if (nbits == 8) begin
              chk("rnd_miso", {10'h0, mi}, {10'h0, cur});
              m_byte(rb);
              m_load(cur);
            end else begin
              chk("rnd_miso_part", {10'h0, mi}, {10'h0, cur >> (8 - nbits)});
              break;
            end
          end
          cs_high();
        end
        default: begin
          reg_read(A_CTRL, rd, idle);
          chk("rnd_ctrl", rd, {16'h0, m_tx_ie, m_rx_ie});
        end
      endcase
      wait_clks(2);
      chk("rnd_irq", {17'h0, irq}, {17'h0, (m_rx_ie & m_rx_valid) | (m_tx_ie & ~m_tx_full)});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
